hazard_ctrl: RTL and testbench

Parametrised hazard/forwarding controller for the 5-stage pipelined MIPS core, sitting beside the datapath and driving its forwarding muxes, the F/D stall enables and the E flush. It generalises the combinational hazard unit with:
- a configurable register-address width;
- a counted post-reset warm-up window;
- a multi-cycle multiply/divide (MDU) busy scoreboard;
- a saturating stall-cycle counter;
- corrected load-use detection for store base registers.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_mdu_sb.sv | 29 ++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings for the hazard/forwarding controller.
// Included by hazard_ctrl and hazard_mdu_sb.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  // M wins over W when both stages write the same register.
  function automatic fwd_sel_t fwdSel(
    input logic hitM,
    input logic hitW
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (hitM)
      sel = FWD_MEM;
    else if (hitW)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_mdu_sb.sv
// HI/LO busy scoreboard: counts MDU_LAT cycles after an MDU op leaves E.
// Only built when HAZARD_MDU_EN is defined.
import hazard_pkg::*;

module hazard_mdu_sb #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int BW = $clog2(MDU_LAT + 1);

  logic [BW-1:0] busyCnt;

  always_ff @(posedge clk) begin
    if (reset)
      busyCnt <= '0;
    else if (start)
      busyCnt <= BW'(MDU_LAT);
    else if (busyCnt != '0)
      busyCnt <= busyCnt - BW'(1);
  end

  assign busy = (busyCnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Define HAZARD_MDU_EN to build the multiply/divide busy scoreboard.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int REGW    = 5,
  parameter int WARMUP  = 2,
  parameter int MDU_LAT = 4,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            memtoregW,
  input  logic            memwriteD,
  input  logic            memwriteM,
  input  logic            branchD,
  input  logic            mduD,
  input  logic            mduStartE,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            forwardaD,
  output logic            forwardbD,
  output logic            forwardM,
  output logic            stallF,
  output logic            stallD,
  output logic            flushE,
  output logic            mduBusy,
  output logic [CNTW-1:0] stallCount
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [WW-1:0]   warmCnt;
  logic [CNTW-1:0] cnt;
  logic            warm;
  logic            active;
  logic            lwStall;
  logic            brStall;
  logic            mduStall;
  logic            stall;

  always_ff @(posedge clk) begin
    if (reset)
      warmCnt <= WW'(WARMUP);
    else if (warm)
      warmCnt <= warmCnt - WW'(1);
  end

  assign warm   = (warmCnt != '0);
  assign active = !reset && !warm;

  logic aHitM, aHitW, bHitM, bHitW;

  assign aHitM = (rsE != '0) && (rsE == writeregM) && regwriteM;
  assign aHitW = (rsE != '0) && (rsE == writeregW) && regwriteW;
  assign bHitM = (rtE != '0) && (rtE == writeregM) && regwriteM;
  assign bHitW = (rtE != '0) && (rtE == writeregW) && regwriteW;

  assign forwardaE = active ? fwdSel(aHitM, aHitW) : FWD_RF;
  assign forwardbE = active ? fwdSel(bHitM, bHitW) : FWD_RF;

  assign forwardaD = active && (rsD != '0)
                   && (rsD == writeregM) && regwriteM;
  assign forwardbD = active && (rtD != '0)
                   && (rtD == writeregM) && regwriteM;

  assign forwardM = active && memtoregW && memwriteM
                  && (writeregW != '0) && (writeregW == writeregM);

  // Store data is covered by forwardM; only its base register stalls.
  assign lwStall = memtoregE
                 && (((rsD != '0) && (rsD == rtE))
                  || ((rtD != '0) && (rtD == rtE) && !memwriteD));

  assign brStall = branchD
                 && ((regwriteE
                      && ((writeregE == rsD) || (writeregE == rtD)))
                  || (memtoregM
                      && ((writeregM == rsD) || (writeregM == rtD))));

`ifdef HAZARD_MDU_EN
  logic sbBusy;

  hazard_mdu_sb #(
    .MDU_LAT (MDU_LAT)
  ) uMduSb (
    .clk   (clk),
    .reset (reset),
    .start (mduStartE && !flushE),
    .busy  (sbBusy)
  );

  assign mduBusy  = !reset && sbBusy;
  assign mduStall = mduD && (mduBusy || mduStartE);
`else
  logic unusedMdu;

  assign unusedMdu = mduD ^ mduStartE;
  assign mduBusy   = 1'b0;
  assign mduStall  = 1'b0;
`endif

  assign stall  = active && (lwStall || brStall || mduStall);
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (stall && (cnt != '1))
      cnt <= cnt + CNTW'(1);
  end

  assign stallCount = reset ? '0 : cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases then random traffic
// compared against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

  localparam int REGW    = 5;
  localparam int WARMUP  = 2;
  localparam int MDU_LAT = 4;
  localparam int CNTW    = 4;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [REGW-1:0] rsD, rtD, rsE, rtE;
  logic [REGW-1:0] writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW;
  logic memtoregE, memtoregM, memtoregW;
  logic memwriteD, memwriteM, branchD, mduD, mduStartE;
  logic [1:0] forwardaE, forwardbE;
  logic forwardaD, forwardbD, forwardM;
  logic stallF, stallD, flushE, mduBusy;
  logic [CNTW-1:0] stallCount;

  int checks = 0;
  int failures = 0;

  // Model state: cycle index, cycles since release, last accepted MDU start.
  int cyc = 0;
  int relCyc = 0;
  int lastStart = -1000;
  int cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REGW(REGW), .WARMUP(WARMUP), .MDU_LAT(MDU_LAT), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
    .memwriteD(memwriteD), .memwriteM(memwriteM), .branchD(branchD),
    .mduD(mduD), .mduStartE(mduStartE),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardM(forwardM),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .mduBusy(mduBusy), .stallCount(stallCount)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdE(input logic [REGW-1:0] r);
    if (r == 0) return 2'b00;
    if (regwriteM && r == writeregM) return 2'b10;
    if (regwriteW && r == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; memtoregW = 0;
    memwriteD = 0; memwriteM = 0; branchD = 0;
    mduD = 0; mduStartE = 0;
  endtask

  // Check every output against the model, advance model, move to next cycle.
  task automatic step();
    logic act, busy, lw, br, md, st;
    #1;
    act = !reset && (relCyc >= WARMUP);
    busy = 1'b0;
`ifdef HAZARD_MDU_EN
    busy = !reset && (cyc - lastStart >= 1) && (cyc - lastStart <= MDU_LAT);
`endif
    lw = memtoregE && ((rsD != 0 && rsD == rtE)
                    || (rtD != 0 && rtD == rtE && !memwriteD));
    br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD))
                  || (memtoregM && (writeregM == rsD || writeregM == rtD)));
    md = 1'b0;
`ifdef HAZARD_MDU_EN
    md = mduD && (busy || mduStartE);
`endif
    st = act && (lw || br || md);
    chk("fwdaE", 32'(forwardaE), 32'(act ? fwdE(rsE) : 2'b00));
    chk("fwdbE", 32'(forwardbE), 32'(act ? fwdE(rtE) : 2'b00));
    chk("fwdaD", 32'(forwardaD),
        32'(act && rsD != 0 && rsD == writeregM && regwriteM));
    chk("fwdbD", 32'(forwardbD),
        32'(act && rtD != 0 && rtD == writeregM && regwriteM));
    chk("fwdM", 32'(forwardM), 32'(act && memtoregW && memwriteM
        && writeregW != 0 && writeregW == writeregM));
    chk("stallF", 32'(stallF), 32'(st));
    chk("stallD", 32'(stallD), 32'(st));
    chk("flushE", 32'(flushE), 32'(st));
    chk("mduBusy", 32'(mduBusy), 32'(busy));
    chk("stallCount", 32'(stallCount), reset ? 32'd0 : 32'(cnt));
    if (reset) begin
      relCyc = 0;
      lastStart = -1000;
      cnt = 0;
    end else begin
      relCyc++;
      if (st && cnt < CMAX) cnt++;
`ifdef HAZARD_MDU_EN
      if (mduStartE && !st) lastStart = cyc;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1;
    @(negedge clk);
    step();
    step();

    // Warm-up window: forward suppressed two cycles, then from M.
    reset = 0;
    rsE = 3; writeregM = 3; regwriteM = 1;
    #1 chk("warm0", 32'(forwardaE), 32'd0);
    step();
    #1 chk("warm1", 32'(forwardaE), 32'd0);
    step();
    #1 chk("warm2", 32'(forwardaE), 32'd2);
    step();

    // Load-use: store base stalls, store data does not.
    clr();
    memtoregE = 1; rtE = 5; rsD = 5; memwriteD = 1;
    #1 chk("lwBase", 32'(stallF), 32'd1);
    step();
    rtD = 5; rsD = 0;
    #1 chk("lwData", 32'(stallF), 32'd0);
    step();
    memtoregW = 1; memwriteM = 1; writeregW = 5; writeregM = 5;
    #1 chk("fwdMem", 32'(forwardM), 32'd1);
    step();

    // M beats W; register 0 never forwards.
    clr();
    rsE = 4; writeregM = 4; writeregW = 4; regwriteM = 1; regwriteW = 1;
    #1 chk("fwdPri", 32'(forwardaE), 32'd2);
    step();
    rsE = 0;
    #1 chk("fwdZero", 32'(forwardaE), 32'd0);
    step();

    // Branch hazards from E (ALU) and M (load).
    clr();
    branchD = 1; regwriteE = 1; writeregE = 7; rtD = 7;
    #1 chk("brE", 32'(flushE), 32'd1);
    step();
    clr();
    branchD = 1; memtoregM = 1; writeregM = 7; rsD = 7;
    #1 chk("brM", 32'(stallD), 32'd1);
    step();

    clr();
`ifdef HAZARD_MDU_EN
    mduStartE = 1;
    step();
    mduStartE = 0;
    mduD = 1;
    for (int k = 1; k <= MDU_LAT; k++) begin
      #1 chk("mduHold", 32'(stallF), 32'd1);
      step();
    end
    #1 chk("mduFree", 32'(stallF), 32'd0);
    step();
    // A start that is itself flushed does not load the scoreboard.
    mduStartE = 1;
    #1 chk("mduSame", 32'(stallF), 32'd1);
    step();
    mduStartE = 0;
    #1 chk("mduNoLoad", 32'(mduBusy), 32'd0);
    step();
    // Reset in the middle of an MDU op clears busy.
    clr();
    mduStartE = 1;
    step();
    mduStartE = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    #1 chk("mduRst", 32'(mduBusy), 32'd0);
    step();
    step();
`else
    mduD = 1; mduStartE = 1;
    #1 chk("mduOff", 32'(stallF), 32'd0);
    step();
    #1 chk("mduOffBusy", 32'(mduBusy), 32'd0);
    step();
`endif

    // Counter saturation.
    clr();
    reset = 1;
    step();
    reset = 0;
    step();
    step();
    memtoregE = 1; rtE = 2; rsD = 2;
    repeat (20) step();
    #1 chk("satCnt", 32'(stallCount), 32'(CMAX));
    step();

    // Random traffic on a small register range to provoke matches.
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      rsD       = REGW'($urandom_range(0, 3));
      rtD       = REGW'($urandom_range(0, 3));
      rsE       = REGW'($urandom_range(0, 3));
      rtE       = REGW'($urandom_range(0, 3));
      writeregE = REGW'($urandom_range(0, 3));
      writeregM = REGW'($urandom_range(0, 3));
      writeregW = REGW'($urandom_range(0, 3));
      regwriteE = ($urandom_range(0, 1) == 0);
      regwriteM = ($urandom_range(0, 1) == 0);
      regwriteW = ($urandom_range(0, 1) == 0);
      memtoregE = ($urandom_range(0, 2) == 0);
      memtoregM = ($urandom_range(0, 2) == 0);
      memtoregW = ($urandom_range(0, 2) == 0);
      memwriteD = ($urandom_range(0, 2) == 0);
      memwriteM = ($urandom_range(0, 2) == 0);
      branchD   = ($urandom_range(0, 3) == 0);
      mduD      = ($urandom_range(0, 2) == 0);
      mduStartE = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
